// File: rtl/eigen_pkg.sv
// Shared constants and state encoding for the eigenvector register-file loader,
// the register file itself and the projection datapath.
package eigen_pkg;
    localparam int PIX_W          = 16;
    localparam int EIG_W          = 4;
    localparam int DEF_NUM_PIXELS = 161;
    localparam int DEF_COLS_SIZE  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRECLR,
        ST_LOAD,
        ST_DONE,
        ST_WIPE
    } eigen_ld_state_t;
endpackage

// File: rtl/eigen_idx_counter.sv
// Pixel-major 2-D wrap counter: pixel runs 0..NUM_PIXELS-1, then eigen advances.
module eigen_idx_counter
    import eigen_pkg::*;
#(
    parameter int NUM_PIXELS = DEF_NUM_PIXELS,
    parameter int COLS_SIZE  = DEF_COLS_SIZE
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [PIX_W-1:0] o_pixel,
    output logic [EIG_W-1:0] o_eigen,
    output logic             o_last
);
    localparam logic [PIX_W-1:0] PIX_MAX = PIX_W'(NUM_PIXELS - 1);
    localparam logic [EIG_W-1:0] EIG_MAX = EIG_W'(COLS_SIZE - 1);

    logic [PIX_W-1:0] r_pixel;
    logic [EIG_W-1:0] r_eigen;
    logic             w_pix_wrap;
    logic             w_eig_wrap;

    assign w_pix_wrap = (r_pixel == PIX_MAX);
    assign w_eig_wrap = (r_eigen == EIG_MAX);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pixel <= '0;
            r_eigen <= '0;
        end else if (i_clr) begin
            r_pixel <= '0;
            r_eigen <= '0;
        end else if (i_inc) begin
            if (w_pix_wrap) begin
                r_pixel <= '0;
                r_eigen <= w_eig_wrap ? '0 : r_eigen + 1'b1;
            end else begin
                r_pixel <= r_pixel + 1'b1;
            end
        end
    end

    assign o_pixel = r_pixel;
    assign o_eigen = r_eigen;
    assign o_last  = w_pix_wrap & w_eig_wrap;
endmodule

// File: rtl/eigen_load_ctrl.sv
// Streams COLS_SIZE x NUM_PIXELS ingress words into the eigenvector register file,
// clearing it first and reporting completion to the projection datapath.
module eigen_load_ctrl
    import eigen_pkg::*;
#(
    parameter int NUM_PIXELS = DEF_NUM_PIXELS,
    parameter int COLS_SIZE  = DEF_COLS_SIZE
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_clear_req,
    input  logic             i_abort,
    input  logic             i_in_valid,
    input  logic [31:0]      i_in_data,
    output logic             o_in_ready,
    output logic             o_reg_enable,
    output logic             o_reg_clear,
    output logic [PIX_W-1:0] o_pixel_iter,
    output logic [EIG_W-1:0] o_eigen_iter,
    output logic [31:0]      o_reg_data,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_loaded
);
    eigen_ld_state_t  r_state, w_next;
    logic             r_loaded;
    logic             r_en_q;
    logic [31:0]      r_data;
    logic [PIX_W-1:0] r_pix;
    logic [EIG_W-1:0] r_eig;

    logic             w_in_ready, w_accept, w_reg_clear, w_busy, w_done, w_cnt_clr;
    logic [PIX_W-1:0] w_cnt_pix;
    logic [EIG_W-1:0] w_cnt_eig;
    logic             w_cnt_last;

    eigen_idx_counter #(
        .NUM_PIXELS (NUM_PIXELS),
        .COLS_SIZE  (COLS_SIZE)
    ) u_idx (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (w_accept),
        .i_clr   (w_cnt_clr),
        .o_pixel (w_cnt_pix),
        .o_eigen (w_cnt_eig),
        .o_last  (w_cnt_last)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_reg_clear = 1'b0;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        w_cnt_clr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (i_start)          w_next = ST_PRECLR;
                else if (i_clear_req) w_next = ST_WIPE;
            end
            ST_PRECLR: begin
                w_reg_clear = 1'b1;
                w_cnt_clr   = 1'b1;
                w_next      = ST_LOAD;
            end
            ST_LOAD: begin
                // abort blocks the word presented in the same cycle
                w_in_ready = ~i_abort;
                if (i_abort)                        w_next = ST_WIPE;
                else if (i_in_valid && w_cnt_last)  w_next = ST_DONE;
            end
            ST_DONE: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            ST_WIPE: begin
                w_reg_clear = 1'b1;
                w_next      = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_accept = w_in_ready & i_in_valid;

    // loaded flips on the transition so it is already valid during DONE/PRECLR/WIPE
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_loaded <= 1'b0;
            r_en_q   <= 1'b0;
            r_data   <= '0;
            r_pix    <= '0;
            r_eig    <= '0;
        end else begin
            r_en_q <= w_accept;
            if (w_accept) begin
                r_data <= i_in_data;
                r_pix  <= w_cnt_pix;
                r_eig  <= w_cnt_eig;
            end
            if (w_next == ST_DONE && r_state == ST_LOAD)
                r_loaded <= 1'b1;
            else if (w_next == ST_PRECLR || w_next == ST_WIPE)
                r_loaded <= 1'b0;
        end
    end

    assign o_in_ready   = w_in_ready;
    assign o_reg_enable = r_en_q & ~w_reg_clear;
    assign o_reg_clear  = w_reg_clear;
    assign o_pixel_iter = r_pix;
    assign o_eigen_iter = r_eig;
    assign o_reg_data   = r_data;
    assign o_busy       = w_busy;
    assign o_done       = w_done;
    assign o_loaded     = r_loaded;
endmodule

// File: tb/tb_eigen_load_ctrl.sv
// Scoreboard bench for eigen_load_ctrl: accepted words are queued just before the
// edge and matched against each register-file write one cycle later.
module tb_eigen_load_ctrl;
    localparam int NP = 161;
    localparam int CS = 8;
    localparam int N  = NP * CS;

    typedef struct {
        int          pix;
        int          eig;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, clear_req = 1'b0, abort = 1'b0, in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        o_in_ready, o_reg_enable, o_reg_clear, o_busy, o_done, o_loaded;
    logic [15:0] o_pixel_iter;
    logic [3:0]  o_eigen_iter;
    logic [31:0] o_reg_data;
    logic [57:0] outs;

    int   checks = 0, errors = 0;
    int   acc_cnt = 0, wr_cnt = 0, done_cnt = 0;
    exp_t sbq[$];
    exp_t e;
    logic exp_last;

    eigen_load_ctrl #(.NUM_PIXELS(NP), .COLS_SIZE(CS)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_clear_req  (clear_req),
        .i_abort      (abort),
        .i_in_valid   (in_valid),
        .i_in_data    (in_data),
        .o_in_ready   (o_in_ready),
        .o_reg_enable (o_reg_enable),
        .o_reg_clear  (o_reg_clear),
        .o_pixel_iter (o_pixel_iter),
        .o_eigen_iter (o_eigen_iter),
        .o_reg_data   (o_reg_data),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_loaded     (o_loaded)
    );

    always #5 clk = ~clk;

    assign outs = {o_in_ready, o_reg_enable, o_reg_clear, o_busy, o_done, o_loaded,
                   o_pixel_iter, o_eigen_iter, o_reg_data};

    // Acceptance sampled 1 ns before the rising edge, with inputs long settled.
    always begin
        @(negedge clk);
        #4;
        if (rst === 1'b0 && in_valid === 1'b1 && o_in_ready === 1'b1) begin
            sbq.push_back('{acc_cnt % NP, acc_cnt / NP, in_data});
            acc_cnt++;
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0 && o_reg_enable === 1'b1) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got pixel=%0d eigen=%0d data=%0d, expected no write",
                         o_pixel_iter, o_eigen_iter, o_reg_data);
            end else begin
                e = sbq.pop_front();
                wr_cnt++;
                if (o_pixel_iter !== 16'(e.pix) || o_eigen_iter !== 4'(e.eig) || o_reg_data !== e.data) begin
                    errors++;
                    $display("FAIL write_data: got (%0d,%0d)=%0d expected (%0d,%0d)=%0d",
                             o_eigen_iter, o_pixel_iter, o_reg_data, e.eig, e.pix, e.data);
                end
                exp_last = (e.pix == NP - 1) && (e.eig == CS - 1);
                checks++;
                if (o_done !== exp_last) begin
                    errors++;
                    $display("FAIL done_align: got done=%0b expected %0b at (%0d,%0d)",
                             o_done, exp_last, e.eig, e.pix);
                end
            end
        end
        if (rst === 1'b0 && o_done === 1'b1) done_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        #1;
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", outs); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL idle_outputs: got %h expected 0", outs); end
    endtask

    task automatic test_full_load();
        @(negedge clk);
        acc_cnt = 0; wr_cnt = 0; done_cnt = 0;
        start = 1'b1; in_valid = 1'b1; in_data = 0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({o_reg_clear, o_in_ready, o_busy, o_reg_enable, o_loaded} !== 5'b10100) begin
            errors++;
            $display("FAIL preclr_cycle: got clr/rdy/busy/en/loaded=%b expected 10100",
                     {o_reg_clear, o_in_ready, o_busy, o_reg_enable, o_loaded});
        end
        for (int c = 2; c <= N + 1; c++) begin
            @(negedge clk);
            in_data = 32'(acc_cnt);
            if (c == 2) begin
                checks++;
                if (o_in_ready !== 1'b1 || o_reg_enable !== 1'b0) begin
                    errors++;
                    $display("FAIL first_accept: got rdy=%0b en=%0b expected 1 0", o_in_ready, o_reg_enable);
                end
            end
            if (c == 3) begin
                checks++;
                if (o_reg_enable !== 1'b1 || o_pixel_iter !== 16'd0 || o_eigen_iter !== 4'd0 || o_reg_data !== 32'd0) begin
                    errors++;
                    $display("FAIL first_write: got en=%0b (%0d,%0d)=%0d expected 1 (0,0)=0",
                             o_reg_enable, o_eigen_iter, o_pixel_iter, o_reg_data);
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if ({o_done, o_loaded, o_reg_enable, o_in_ready} !== 4'b1110 || o_pixel_iter !== 16'd160 ||
            o_eigen_iter !== 4'd7 || o_reg_data !== 32'd1287) begin
            errors++;
            $display("FAIL last_write: got done/loaded/en/rdy=%b (%0d,%0d)=%0d expected 1110 (7,160)=1287",
                     {o_done, o_loaded, o_reg_enable, o_in_ready}, o_eigen_iter, o_pixel_iter, o_reg_data);
        end
        @(negedge clk);
        checks++;
        if ({o_busy, o_done, o_loaded} !== 3'b001) begin
            errors++;
            $display("FAIL post_done_idle: got busy/done/loaded=%b expected 001", {o_busy, o_done, o_loaded});
        end
        checks++;
        if (wr_cnt != N || done_cnt != 1) begin
            errors++;
            $display("FAIL full_counts: got writes=%0d dones=%0d expected %0d 1", wr_cnt, done_cnt, N);
        end
    endtask

    task automatic test_gaps();
        bit got = 0;
        @(negedge clk);
        acc_cnt = 0; wr_cnt = 0; done_cnt = 0;
        start = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 20000 && !got; c++) begin
            @(negedge clk);
            in_valid = ($urandom_range(99) < 50);
            in_data  = 32'(acc_cnt);
            if (o_done === 1'b1) got = 1;
        end
        in_valid = 1'b0;
        checks++;
        if (!got) begin errors++; $display("FAIL gap_timeout: got no done, expected done within 20000 cycles"); end
        @(negedge clk);
        checks++;
        if (wr_cnt != N || done_cnt != 1 || o_loaded !== 1'b1 || sbq.size() != 0) begin
            errors++;
            $display("FAIL gap_counts: got writes=%0d dones=%0d loaded=%0b pending=%0d expected %0d 1 1 0",
                     wr_cnt, done_cnt, o_loaded, sbq.size(), N);
        end
    endtask

    task automatic test_abort();
        int dc;
        @(negedge clk);
        acc_cnt = 0; wr_cnt = 0;
        start = 1'b1; in_valid = 1'b1; in_data = 0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 1000 && acc_cnt < 300; c++) begin
            @(negedge clk);
            in_data = 32'(acc_cnt);
        end
        dc = done_cnt;
        abort = 1'b1;
        #1;
        checks++;
        if (o_in_ready !== 1'b0 || o_busy !== 1'b1 || acc_cnt != 300) begin
            errors++;
            $display("FAIL abort_ready: got rdy=%0b busy=%0b accepts=%0d expected 0 1 300", o_in_ready, o_busy, acc_cnt);
        end
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0;
        checks++;
        if (o_reg_clear !== 1'b1 || o_reg_enable !== 1'b0 || acc_cnt != 300) begin
            errors++;
            $display("FAIL abort_wipe: got clr=%0b en=%0b accepts=%0d expected 1 0 300", o_reg_clear, o_reg_enable, acc_cnt);
        end
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || o_loaded !== 1'b0 || done_cnt != dc || wr_cnt != 300 || sbq.size() != 0) begin
            errors++;
            $display("FAIL abort_idle: got busy=%0b loaded=%0b newdone=%0d writes=%0d expected 0 0 0 300",
                     o_busy, o_loaded, done_cnt - dc, wr_cnt);
        end
    endtask

    task automatic test_clear();
        checks++;
        if (o_loaded !== 1'b1) begin errors++; $display("FAIL clear_pre: got loaded=%0b expected 1", o_loaded); end
        @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        checks++;
        if ({o_reg_clear, o_loaded, o_busy, o_in_ready} !== 4'b1010) begin
            errors++;
            $display("FAIL clear_wipe: got clr/loaded/busy/rdy=%b expected 1010", {o_reg_clear, o_loaded, o_busy, o_in_ready});
        end
        @(negedge clk);
        checks++;
        if ({o_reg_clear, o_loaded, o_busy} !== 3'b000) begin
            errors++;
            $display("FAIL clear_idle: got clr/loaded/busy=%b expected 000", {o_reg_clear, o_loaded, o_busy});
        end
        // start wins over clear_req: PRECLR is followed by LOAD, not IDLE
        @(negedge clk);
        start = 1'b1; clear_req = 1'b1;
        @(negedge clk);
        start = 1'b0; clear_req = 1'b0;
        @(negedge clk);
        checks++;
        if (o_in_ready !== 1'b1 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL start_priority: got rdy=%0b busy=%0b expected 1 1", o_in_ready, o_busy);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_midload();
        @(negedge clk);
        acc_cnt = 0; wr_cnt = 0;
        start = 1'b1; in_valid = 1'b1; in_data = 0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 2000 && acc_cnt < 700; c++) begin
            @(negedge clk);
            in_data = 32'(acc_cnt);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL async_reset: got %h expected 0", outs); end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        sbq.delete();
        @(negedge clk);
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL reset_release: got %h expected 0", outs); end
        test_full_load();
    endtask

    task automatic test_start_ignored();
        bit got = 0;
        @(negedge clk);
        acc_cnt = 0; wr_cnt = 0; done_cnt = 0;
        start = 1'b1; in_valid = 1'b1; in_data = 0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 3000 && !got; c++) begin
            @(negedge clk);
            in_data = 32'(acc_cnt);
            start = (c == 500) || (o_done === 1'b1);
            if (o_done === 1'b1) got = 1;
        end
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        checks++;
        if (!got || o_busy !== 1'b0 || o_reg_clear !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done: got done_seen=%0b busy=%0b clr=%0b expected 1 0 0", got, o_busy, o_reg_clear);
        end
        @(negedge clk);
        checks++;
        if (wr_cnt != N || done_cnt != 1 || o_loaded !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored_counts: got writes=%0d dones=%0d loaded=%0b busy=%0b expected %0d 1 1 0",
                     wr_cnt, done_cnt, o_loaded, o_busy, N);
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_gaps();
        test_clear();
        test_abort();
        test_reset_midload();
        test_start_ignored();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
